shared_adder_arb: RTL and testbench

SHARED_ADDER_ARB -- requirements
Module: shared_adder_arb

---
 rtl/shared_adder_arb.sv | 120 ++++++++++++
 tb/tb_shared_adder_arb.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shared_adder_arb.sv
// ============================================================================
// Module   : shared_adder_arb
// Purpose  : One WIDTH-bit adder shared by four requesters; round-robin grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shared_adder_arb #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  input  logic [3:0]           cin,
  output logic [3:0]           gnt,
  output logic                 busy,
  output logic                 res_valid,
  output logic [1:0]           res_id,
  output logic [WIDTH-1:0]     res_sum,
  output logic                 res_cout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [1:0]       r_last_grant;
  logic [1:0]       r_winner;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [1:0]       w_winner;
  logic [1:0]       w_idx;
  logic             w_found;

  // Search starts one past the last grant; offset 4 wraps back to last_grant itself.
  always_comb begin
    w_winner = r_last_grant;
    w_idx    = r_last_grant;
    w_found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_idx = r_last_grant + 2'(i + 1);
      if (!w_found && req[w_idx]) begin
        w_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req != 4'b0000) w_next_state = EXEC;
      EXEC:    w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt          <= 4'b0000;
      res_valid    <= 1'b0;
      res_id       <= 2'd0;
      res_sum      <= '0;
      res_cout     <= 1'b0;
      r_last_grant <= 2'd3;
      r_winner     <= 2'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          res_valid <= 1'b0;
          if (req != 4'b0000) begin
            gnt      <= 4'b0001 << w_winner;
            r_winner <= w_winner;
            r_a      <= a_in[int'(w_winner)*WIDTH +: WIDTH];
            r_b      <= b_in[int'(w_winner)*WIDTH +: WIDTH];
            r_cin    <= cin[w_winner];
          end else begin
            gnt <= 4'b0000;
          end
        end
        EXEC: begin
          gnt                 <= 4'b0000;
          {res_cout, res_sum} <= {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
          res_id              <= r_winner;
          res_valid           <= 1'b1;
        end
        DONE: begin
          gnt          <= 4'b0000;
          res_valid    <= 1'b0;
          r_last_grant <= r_winner;
        end
        default: begin
          gnt       <= 4'b0000;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_shared_adder_arb.sv
// ============================================================================
// Module   : tb_shared_adder_arb
// Purpose  : Directed plus randomized self-checking bench for shared_adder_arb.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_shared_adder_arb;
  localparam int WIDTH = 4;
  localparam int AW    = 4 * WIDTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [AW-1:0]    a_in;
  logic [AW-1:0]    b_in;
  logic [3:0]       cin;
  logic [3:0]       gnt;
  logic             busy;
  logic             res_valid;
  logic [1:0]       res_id;
  logic [WIDTH-1:0] res_sum;
  logic             res_cout;

  int n_checks = 0;
  int n_fail   = 0;
  int lg       = 3;  // model of the last granted requester

  always #5 clk = ~clk;

  shared_adder_arb #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .res_cout  (res_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int off = 1; off <= 4; off++)
      if (r[(lg + off) % 4]) return (lg + off) % 4;
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".gnt"},   {28'd0, gnt}, 32'd0);
    check({tag, ".busy"},  {31'd0, busy}, 32'd0);
    check({tag, ".valid"}, {31'd0, res_valid}, 32'd0);
    check({tag, ".id"},    {30'd0, res_id}, 32'd0);
    check({tag, ".sum"},   32'(res_sum), 32'd0);
    check({tag, ".cout"},  {31'd0, res_cout}, 32'd0);
  endtask

  // One full operation: grant, result, return to IDLE. junk scrambles inputs while busy.
  task automatic do_op(input logic [3:0] r, input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [3:0] c, input bit junk);
    int w;
    int exp_total;
    req  = r;
    a_in = a;
    b_in = b;
    cin  = c;
    w = pick(r);
    exp_total = int'(a[w*WIDTH +: WIDTH]) + int'(b[w*WIDTH +: WIDTH]) + int'(c[w]);
    step();
    check("grant", {28'd0, gnt}, 32'd1 << w);
    check("busy_exec", {31'd0, busy}, 32'd1);
    check("valid_exec", {31'd0, res_valid}, 32'd0);
    if (junk) begin
      req = 4'($urandom); a_in = AW'($urandom); b_in = AW'($urandom); cin = 4'($urandom);
    end
    step();
    check("valid_done", {31'd0, res_valid}, 32'd1);
    check("res_id", {30'd0, res_id}, 32'(w));
    check("res_sum", 32'(res_sum), 32'(exp_total % (1 << WIDTH)));
    check("res_cout", {31'd0, res_cout}, 32'(exp_total >> WIDTH));
    check("gnt_clear", {28'd0, gnt}, 32'd0);
    check("busy_done", {31'd0, busy}, 32'd1);
    if (junk) begin
      req = 4'($urandom); a_in = AW'($urandom); b_in = AW'($urandom); cin = 4'($urandom);
    end
    step();
    check("valid_idle", {31'd0, res_valid}, 32'd0);
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("sum_hold", 32'(res_sum), 32'(exp_total % (1 << WIDTH)));
    check("id_hold", {30'd0, res_id}, 32'(w));
    lg = w;
    if (junk) req = 4'b0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #1;
    check_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    lg = 3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] r;
    rst_n = 1'b1;
    req   = 4'b0000;
    a_in  = '0;
    b_in  = '0;
    cin   = 4'b0000;
    #2;
    do_reset();

    // Idle with no requests
    step();
    check("idle_gnt", {28'd0, gnt}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Basic sums: 7+5, F+1+1 with carry-out
    do_op(4'b0001, 16'h0007, 16'h0005, 4'b0000, 1'b0);
    do_op(4'b0010, 16'h00F0, 16'h0010, 4'b0010, 1'b0);

    // All four requesting continuously from reset: 0,1,2,3,0 back to back
    do_reset();
    for (int i = 0; i < 5; i++)
      do_op(4'b1111, 16'h4321, 16'h8765, 4'b1010, 1'b0);

    // Wrap-around: last_grant = 2, then 1011 -> 3, then 1011 -> 0
    do_op(4'b0100, 16'h0900, 16'h0800, 4'b0100, 1'b1);
    do_op(4'b1011, 16'hA000, 16'h7000, 4'b1000, 1'b1);
    do_op(4'b1011, 16'h000C, 16'h0003, 4'b0001, 1'b1);

    // Reset asserted during EXEC aborts the operation
    req  = 4'b0010;
    a_in = 16'h0030;
    b_in = 16'h0040;
    step();
    check("abort_gnt", {28'd0, gnt}, 32'h2);
    rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    req = 4'b0000;
    step();
    check("abort_novalid", {31'd0, res_valid}, 32'd0);
    rst_n = 1'b1;
    lg = 3;
    step();
    check("abort_novalid2", {31'd0, res_valid}, 32'd0);
    do_op(4'b0100, 16'h0500, 16'h0600, 4'b0000, 1'b0);

    // Randomized operations with inputs scrambled while busy
    for (int i = 0; i < 24; i++) begin
      r = 4'($urandom);
      if (r == 4'b0000) begin
        req = r;
        step();
        check("rand_idle_gnt", {28'd0, gnt}, 32'd0);
        check("rand_idle_busy", {31'd0, busy}, 32'd0);
      end else begin
        do_op(r, AW'($urandom), AW'($urandom), 4'($urandom), 1'b1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
